// File: rtl/ram_line_bridge_pkg.sv
// Shared types and constants for the cache-line to word-memory bridge.
// Line geometry and FSM state encodings live here.
package ram_line_bridge_pkg;

  localparam int LINE_WORDS = 8;
  localparam int IDX_W      = 3;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBURST = 2'd1,
    RBURST = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/ram_line_bridge_line_word_mux.sv
// Word selector over a cache line.
// Picks word[sel] from a packed line, word 0 in the low bits.
module line_word_mux
  import ram_line_bridge_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [IDX_W-1:0]  sel,
  output logic [WORD_W-1:0] word
);

  // Indexed part-select of the addressed 32-bit word
  always_comb begin
    word = line[{sel, 5'b0} +: WORD_W];
  end

endmodule

// File: rtl/ram_line_bridge.sv
// Serialises line-granular cache requests into word bursts.
// Reads assemble a line; both directions end with a ready pulse.
module ram_line_bridge
  import ram_line_bridge_pkg::*;
#(
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_en,
  input  logic              ram_write,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [LINE_W-1:0] line_wb,
  output logic              ram_ready,
  output logic [LINE_W-1:0] line_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        status,
  output logic [IDX_W-1:0]  beat
);

  state_t                   state_q;
  state_t                   state_d;
  logic [ADDR_W-IDX_W-1:0]  base_q;
  logic [IDX_W-1:0]         beat_q;
  logic [LINE_W-1:0]        wline_q;
  logic [LINE_W-1:0]        line_rd_q;
  logic                     in_burst;
  logic                     last;
  logic                     accept;

  assign in_burst = (state_q == WBURST) || (state_q == RBURST);
  assign last     = (beat_q == IDX_W'(LINE_WORDS - 1));
  assign accept   = (state_q == IDLE) && ram_en;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; RESP always returns to IDLE without sampling ram_en
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (ram_en) state_d = ram_write ? WBURST : RBURST;
      WBURST: if (mem_ack && last) state_d = RESP;
      RBURST: if (mem_ack && last) state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, beat counter and read-line assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= '0;
      beat_q    <= '0;
      wline_q   <= '0;
      line_rd_q <= '0;
    end else begin
      if (accept) begin
        base_q  <= ram_addr[ADDR_W-1:IDX_W];
        beat_q  <= '0;
        wline_q <= line_wb;
      end
      if (in_burst && mem_ack) begin
        if (state_q == RBURST)
          line_rd_q[{beat_q, 5'b0} +: WORD_W] <= mem_rdata;
        if (!last) beat_q <= beat_q + 1'b1;
      end
    end
  end

  line_word_mux u_mux (
    .line (wline_q),
    .sel  (beat_q),
    .word (mem_wdata)
  );

  // Outputs decode registers only, so no input reaches an output
  assign mem_req   = in_burst;
  assign mem_we    = (state_q == WBURST);
  assign mem_addr  = {base_q, beat_q};
  assign ram_ready = (state_q == RESP);
  assign line_rd   = line_rd_q;
  assign status    = state_q;
  assign beat      = beat_q;

endmodule

// File: doc/ram_line_bridge.md
Name: ram_line_bridge

Overview:
- Memory-side stage directly downstream of cache_manage_unit.
- Accepts line-granular requests (ram_en/ram_write/ram_addr, 256-bit write line) and serialises them into a burst of LINE_WORDS 32-bit word transactions on a simple req/ack word-memory port.
- Reads: assembles the returned words into a 256-bit line, then pulses ram_ready.
- Writes: pulses ram_ready once the last word has been acknowledged.

Parameters:
- ADDR_W, 30: word-address width, shared by the cache side and the memory side.
- LINE_WORDS, 8: words per cache line; must be a power of two; fixed at 8 for the 256-bit line.
- IDX_W, 3: beat-index width, log2(LINE_WORDS).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- ram_en  in  1  line request from cache; held stable until ram_ready.
- ram_write  in  1  1 = write back line, 0 = refill line.
- ram_addr  in  ADDR_W  word address of the line; low IDX_W bits ignored.
- line_wb  in  256  write-back line; word i = bits [32i+31:32i].
- ram_ready  out  1  one-cycle completion pulse to cache.
- line_rd  out  256  refilled line; valid when ram_ready=1 after a read.
- mem_req  out  1  word transaction request.
- mem_we  out  1  word write enable; valid with mem_req.
- mem_addr  out  ADDR_W  word address: {line base, beat index}.
- mem_wdata  out  32  write word for the current beat.
- mem_rdata  in  32  read word; sampled on mem_ack.
- mem_ack  in  1  completes the current beat this cycle.
- status  out  2  debug: current FSM state encoding.
- beat  out  IDX_W  debug: current beat index.

Behaviour:
- Reset (rst=1 at posedge) forces:
  - state IDLE.
  - ram_ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - line_rd=0, beat=0, status=IDLE.
  - Applies mid-burst too: the burst is abandoned with no ready pulse. The cache re-issues after reset.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states:
  - IDLE (0): sample ram_en. If 1:
    - Latch base = ram_addr with the low IDX_W bits cleared.
    - Latch ram_write and line_wb.
    - beat<=0; go to WBURST (write) or RBURST (read).
    - mem_req rises the next cycle.
  - WBURST (1):
    - mem_req=1, mem_we=1, mem_addr={base, beat}, mem_wdata = latched word[beat].
    - On mem_ack: if beat==LINE_WORDS-1, go to RESP; else beat<=beat+1.
  - RBURST (2):
    - mem_req=1, mem_we=0, mem_addr={base, beat}.
    - On mem_ack: line_rd word[beat] <= mem_rdata.
    - If beat==LINE_WORDS-1, go to RESP; else beat<=beat+1.
  - RESP (3):
    - ram_ready=1 for exactly this cycle; mem_req=0.
    - ram_en is NOT sampled here.
    - Next state is IDLE unconditionally.
    - The cache has this cycle to change or deassert its request.
- Beat handshake:
  - mem_req stays high continuously across beats.
  - Each cycle with mem_ack=1 retires exactly one beat; the address advances on that edge.
  - Wait states (mem_ack=0) hold addr, wdata and we stable.
- Latency, zero-wait memory (ack every req cycle): request sampled in IDLE at edge E, mem_req high for cycles E+1..E+8, ram_ready high in cycle E+9.
- Back-to-back requests: minimum one IDLE cycle between ram_ready and the next burst's first mem_req cycle.
- line_rd persists after a read until the next read overwrites it. Write bursts never modify it.
- Partially overwritten words after a reset-abandoned read are don't-care (reset clears line_rd anyway).
- mem_ack outside WBURST/RBURST is ignored.
- ram_en, ram_write, ram_addr and line_wb changes during a burst are ignored (latched at accept).
- Beat index wraps to 0 only via re-accept, never by overflow.

Decomposition:
- Shared package/header (alongside status.vh):
  - State encodings IDLE/WBURST/RBURST/RESP.
  - LINE_WORDS, IDX_W, line width 256.
- One natural sub-module: line_word_mux, a combinational select of word[beat] from the 256-bit latched line. Read-side word insertion stays inline.

Test Plan:
- Read, zero-wait memory:
  - Stimulus: ram_addr=0x0000_0013, mem_rdata = 0xA0000000 + mem_addr[2:0].
  - Response: mem_addr 0x10..0x17 in order; ram_ready exactly at E+9; line_rd word i = 0xA0000000+i.
- Write with wait states:
  - Stimulus: ram_write=1, ram_addr=0x20, line_wb word i = 0x1111_1111*i; ack every 3rd req cycle.
  - Response: 8 writes to 0x20..0x27 with matching wdata; addr/wdata stable during waits; single ram_ready; line_rd unchanged.
- Back-to-back, write then read:
  - Stimulus: cache changes the request in the RESP cycle.
  - Response: one IDLE gap; the second burst uses the new address; no extra ready pulse.
- Reset mid-read:
  - Stimulus: rst asserted after 4 acks.
  - Response: next cycle mem_req=0, ram_ready=0, line_rd=0, status=IDLE; a new request then completes normally.
- Spurious inputs:
  - Stimulus: mem_ack=1 while IDLE; ram_addr toggled mid-burst.
  - Response: no state change in IDLE; burst addresses follow the latched base only.
